// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync, blank, border, early active window and coordinates.
module vga_timing_gen #(
  parameter int COUNTER_WIDTH        = 10,
  parameter int H_SYNC               = 96,
  parameter int H_BP                 = 40,
  parameter int H_L_BORDER           = 8,
  parameter int H_ADDR               = 640,
  parameter int H_R_BORDER           = 8,
  parameter int H_FP                 = 8,
  parameter int V_SYNC               = 2,
  parameter int V_BP                 = 25,
  parameter int V_T_BORDER           = 8,
  parameter int V_ADDR               = 480,
  parameter int V_B_BORDER           = 8,
  parameter int V_FP                 = 2,
  parameter bit HS_POLARITY_POSITIVE = 1'b0,
  parameter bit VS_POLARITY_POSITIVE = 1'b0,
  parameter int PX_BUFFER_LATENCY    = 1,
  parameter int SYNC_DELAY           = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     hs,
  output logic                     vs,
  output logic                     blank,
  output logic                     border,
  output logic                     active,
  output logic [COUNTER_WIDTH-1:0] x,
  output logic [COUNTER_WIDTH-1:0] y,
  output logic                     line_start,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_L_BORDER + H_ADDR + H_R_BORDER + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_T_BORDER + V_ADDR + V_B_BORDER + V_FP;
  localparam int HA      = H_SYNC + H_BP + H_L_BORDER;
  localparam int VA      = V_SYNC + V_BP + V_T_BORDER;
  localparam int HE      = HA - PX_BUFFER_LATENCY;

  localparam logic [COUNTER_WIDTH-1:0] H_LAST = COUNTER_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNTER_WIDTH-1:0] V_LAST = COUNTER_WIDTH'(V_TOTAL - 1);
  localparam logic HS_ACT = HS_POLARITY_POSITIVE;
  localparam logic VS_ACT = VS_POLARITY_POSITIVE;
  localparam logic [3:0] SIG_RST = {~HS_ACT, ~VS_ACT, 1'b1, 1'b0};

  if (H_TOTAL > (1 << COUNTER_WIDTH)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > (1 << COUNTER_WIDTH)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds counter range");
  end
  if (PX_BUFFER_LATENCY > HA) begin : g_bad_latency
    $error("vga_timing_gen: PX_BUFFER_LATENCY too large");
  end
  if (SYNC_DELAY > 8) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY too large");
  end

  typedef logic [COUNTER_WIDTH:0] cnt_ext_t;

  // One extra bit so region ends equal to 2^COUNTER_WIDTH stay representable.
  function automatic logic in_rng(input cnt_ext_t val, input int lo, input int hi);
    return (val >= cnt_ext_t'(lo)) && (val < cnt_ext_t'(hi));
  endfunction

  logic [COUNTER_WIDTH-1:0] h, v;
  cnt_ext_t                 hx, vx;
  logic                     hs0, vs0, blank0, border0;
  logic                     h_addr, v_addr, h_win, v_win, h_bord, v_bord, hact;
  logic [3:0]               sig0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_comb begin
    hx      = {1'b0, h};
    vx      = {1'b0, v};
    hs0     = in_rng(hx, 0, H_SYNC) ? HS_ACT : ~HS_ACT;
    vs0     = in_rng(vx, 0, V_SYNC) ? VS_ACT : ~VS_ACT;
    h_addr  = in_rng(hx, HA, HA + H_ADDR);
    v_addr  = in_rng(vx, VA, VA + V_ADDR);
    h_win   = in_rng(hx, H_SYNC + H_BP, HA + H_ADDR + H_R_BORDER);
    v_win   = in_rng(vx, V_SYNC + V_BP, VA + V_ADDR + V_B_BORDER);
    h_bord  = in_rng(hx, H_SYNC + H_BP, HA) || in_rng(hx, HA + H_ADDR, HA + H_ADDR + H_R_BORDER);
    v_bord  = in_rng(vx, V_SYNC + V_BP, VA) || in_rng(vx, VA + V_ADDR, VA + V_ADDR + V_B_BORDER);
    blank0  = ~(h_addr & v_addr);
    border0 = h_win & v_win & (h_bord | v_bord);
    sig0    = {hs0, vs0, blank0, border0};
    hact    = in_rng(hx, HE, HE + H_ADDR);
    active  = hact & v_addr;
    x       = active ? h - COUNTER_WIDTH'(HE) : '0;
    y       = active ? v - COUNTER_WIDTH'(VA) : '0;
    line_start  = en & ~rst & (h == '0);
    frame_start = en & ~rst & (h == '0) & (v == '0);
  end

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign {hs, vs, blank, border} = sig0;
  end else begin : g_delay
    logic [3:0] pipe [SYNC_DELAY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < unsigned'(SYNC_DELAY); i++) pipe[i] <= SIG_RST;
      end else if (en) begin
        pipe[0] <= sig0;
        for (int unsigned i = 1; i < unsigned'(SYNC_DELAY); i++) pipe[i] <= pipe[i-1];
      end
    end

    assign {hs, vs, blank, border} = pipe[SYNC_DELAY-1];
  end

endmodule
